// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU flag-commit stage:
//   - flag bit positions inside the NZCV vector ({N,Z,C,V})
//   - nzcv_t          : 4-bit flag vector
//   - alu_beat_t      : buffered ALU beat {result, tag} at default widths
//   - buf_state_e     : occupancy states of the 2-entry skid buffer
//   - ALU_W / ALU_TAG_W default datapath and tag widths
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W     = 32;
    localparam int ALU_TAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic [ALU_W-1:0]     result;
        logic [ALU_TAG_W-1:0] tag;
    } alu_beat_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_skid_buf2.sv
// ---------------------------------------------------------------------------
// alu_skid_buf2
// Generic 2-entry valid/ready FIFO buffer. Outputs are driven straight from
// the head register, and in_ready depends only on registered occupancy plus
// flush/reset, so there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   T          payload type (defaults to alu_pkg::alu_beat_t)
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (empties buffer, clears entries)
//   flush      synchronous drop of all buffered beats
//   in_valid   upstream beat present
//   in_ready   buffer can accept (count<2, not flushing, not in reset)
//   in_data    upstream payload
//   out_valid  head entry valid
//   out_ready  downstream accepts head
//   out_data   head entry payload
// ---------------------------------------------------------------------------
module alu_skid_buf2
    import alu_pkg::*;
#(
    parameter type T = alu_beat_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    buf_state_e state_q, state_d;
    T           head_q, head_d;
    T           tail_q, tail_d;
    logic       accept;
    logic       transfer;

    assign in_ready  = (state_q != BUF_FULL) & ~flush & rst_n;
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = head_q;
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;

    // Occupancy and entry update. In ONE with a simultaneous accept and
    // transfer the head is overwritten in place, which keeps throughput at
    // one beat per cycle without ever using the tail entry.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        head_d  = in_data;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && !transfer) begin
                        tail_d  = in_data;
                        state_d = BUF_FULL;
                    end else if (!accept && transfer) begin
                        state_d = BUF_EMPTY;
                    end else if (accept && transfer) begin
                        head_d  = in_data;
                    end
                end
                BUF_FULL: begin
                    if (transfer) begin
                        head_d  = tail_q;
                        state_d = BUF_ONE;
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/alu_flag_commit.sv
// ---------------------------------------------------------------------------
// alu_flag_commit
// Downstream stage of the ALU: buffers each ALU beat (result, tag) through a
// 2-entry skid buffer toward register-file writeback, owns the architectural
// NZCV register and returns the stored carry to the ALU for ADCS/SBCS.
//
// Configuration macro:
//   ALU_CARRY_BYPASS_EN  when defined, carry_to_alu forwards the carry of a
//                        flag-setting beat being accepted this cycle;
//                        otherwise it is the registered C flag only.
//
// Parameters: W (result width), TAG_W (destination tag width)
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop buffered beats (flags kept)
//   in_valid/in_ready    ALU beat handshake
//   in_result, in_tag    beat payload
//   in_nzcv              ALU flags {N,Z,C,V}
//   in_set_flags         beat updates the flag register
//   out_valid/out_ready  writeback handshake
//   out_result, out_tag  head beat payload
//   apsr_nzcv            architectural flags {N,Z,C,V}
//   carry_to_alu         carry-in for the next ALU op
// ---------------------------------------------------------------------------
module alu_flag_commit
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_result,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [3:0]       in_nzcv,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       apsr_nzcv,
    output logic             carry_to_alu
);

    typedef struct packed {
        logic [W-1:0]     result;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t in_beat;
    beat_t out_beat;
    nzcv_t apsr_q, apsr_d;
    logic  flag_commit;

    assign in_beat.result = in_result;
    assign in_beat.tag    = in_tag;

    alu_skid_buf2 #(
        .T(beat_t)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_beat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_beat)
    );

    assign out_result = out_beat.result;
    assign out_tag    = out_beat.tag;

    // Flags commit when the beat is accepted, not when it leaves the buffer,
    // so a dependent carry-consuming op sees the new carry one cycle later
    // even under writeback backpressure. in_ready is low during flush and
    // reset, which blocks any flag update in those cycles.
    assign flag_commit = in_valid & in_ready & in_set_flags;

    always_comb begin
        apsr_d = apsr_q;
        if (flag_commit) begin
            apsr_d = in_nzcv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            apsr_q <= '0;
        end else begin
            apsr_q <= apsr_d;
        end
    end

    assign apsr_nzcv = apsr_q;

`ifdef ALU_CARRY_BYPASS_EN
    // Same-cycle forwarding of the producer's carry; the forwarded bit
    // depends on in_valid, so the upstream ALU must not derive in_valid
    // from carry_to_alu.
    assign carry_to_alu = flag_commit ? in_nzcv[FLAG_C] : apsr_q[FLAG_C];
`else
    assign carry_to_alu = apsr_q[FLAG_C];
`endif

endmodule

// File: tb/tb_alu_flag_commit.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_commit
// Directed bench for alu_flag_commit with a beat scoreboard: beats are queued
// when accepted and compared in order when they leave the buffer.
// ---------------------------------------------------------------------------
module tb_alu_flag_commit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_tag;
    logic [3:0]  in_nzcv;
    logic        in_set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [3:0]  apsr_nzcv;
    logic        carry_to_alu;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          startCyc;
    alu_beat_t   sb[$];
    alu_beat_t   expBeat;

    always #5 clk = ~clk;

    alu_flag_commit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_tag      (in_tag),
        .in_nzcv     (in_nzcv),
        .in_set_flags(in_set_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .apsr_nzcv   (apsr_nzcv),
        .carry_to_alu(carry_to_alu)
    );

    // Single comparison point: counts the test and reports a failure.
    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Drive one beat and hold it until accepted (bounded), returning just
    // after the accepting edge with in_valid still asserted.
    task automatic applyStimulus(input logic [31:0] r, input logic [3:0] t,
                                 input logic [3:0] nz, input logic sf);
        in_valid     = 1'b1;
        in_result    = r;
        in_tag       = t;
        in_nzcv      = nz;
        in_set_flags = sf;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        checkOutput("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Let the buffer empty with out_ready high, bounded by a cycle budget.
    task automatic drainQueue();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_sb_empty", sb.size(), 0);
        checkOutput("drain_out_valid", out_valid, 0);
    endtask

    // Scoreboard: pop/compare on transfer, push on accept, discard on
    // flush or reset (beats in the buffer are dropped at that edge).
    always @(posedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            checkOutput("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                expBeat = sb.pop_front();
                checkOutput("sb_result", out_result, expBeat.result);
                checkOutput("sb_tag", out_tag, expBeat.tag);
            end
        end
        if (in_valid && in_ready) begin
            expBeat.result = in_result;
            expBeat.tag    = in_tag;
            sb.push_back(expBeat);
        end
        if (!rst_n || flush) sb.delete();
    end

    initial begin
        // Reset held two edges with a pending beat.
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b1;
        in_result    = 32'hDEAD;
        in_tag       = 4'd9;
        in_nzcv      = 4'b1111;
        in_set_flags = 1'b1;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_apsr", apsr_nzcv, 4'b0000);
        checkOutput("rst_carry", carry_to_alu, 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_tag", out_tag, 0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        in_set_flags = 1'b0;

        // SBCS producer: 5-3 with borrow -> result 1, C=1.
        in_valid     = 1'b1;
        in_result    = 32'd1;
        in_tag       = 4'd3;
        in_nzcv      = 4'b0010;
        in_set_flags = 1'b1;
        @(negedge clk);
        checkOutput("sbcs_in_ready", in_ready, 1);
`ifdef ALU_CARRY_BYPASS_EN
        checkOutput("sbcs_carry_same_cycle", carry_to_alu, 1);
`else
        checkOutput("sbcs_carry_same_cycle", carry_to_alu, 0);
`endif
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_set_flags = 1'b0;
        checkOutput("sbcs_apsr", apsr_nzcv, 4'b0010);
        checkOutput("sbcs_carry", carry_to_alu, 1);
        checkOutput("sbcs_out_valid", out_valid, 1);
        checkOutput("sbcs_out_result", out_result, 1);

        // Non-flag op accepted while the previous beat transfers.
        in_valid     = 1'b1;
        in_result    = 32'd7;
        in_tag       = 4'd5;
        in_nzcv      = 4'b1001;
        in_set_flags = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("nonflag_apsr", apsr_nzcv, 4'b0010);
        checkOutput("nonflag_carry", carry_to_alu, 1);
        checkOutput("nonflag_out_result", out_result, 7);
        checkOutput("nonflag_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        checkOutput("nonflag_drained", out_valid, 0);

        // Backpressure: fill, check stall and data hold, then release.
        out_ready = 1'b0;
        applyStimulus(32'hA, 4'd1, 4'b0000, 1'b0);
        applyStimulus(32'hB, 4'd2, 4'b0000, 1'b0);
        in_result = 32'hC;
        in_tag    = 4'd3;
        @(negedge clk);
        checkOutput("bp_full_in_ready", in_ready, 0);
        checkOutput("bp_head_result", out_result, 32'hA);
        @(posedge clk);
        #1;
        checkOutput("bp_hold_result", out_result, 32'hA);
        checkOutput("bp_hold_tag", out_tag, 1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_no_out_ready_path", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("bp_after_release_result", out_result, 32'hB);
        @(negedge clk);
        checkOutput("bp_c_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drainQueue();
        checkOutput("bp_apsr", apsr_nzcv, 4'b0010);

        // Streaming 8 beats with out_ready high: one beat per cycle.
        out_ready = 1'b1;
        startCyc  = cyc;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h100 + i, i[3:0], 4'b0000, 1'b0);
        end
        in_valid = 1'b0;
        checkOutput("stream_cycles", cyc - startCyc, 8);
        drainQueue();

        // Flush with a full buffer and a flag-setting beat pending.
        out_ready = 1'b0;
        applyStimulus(32'h55, 4'd6, 4'b0000, 1'b0);
        applyStimulus(32'h66, 4'd7, 4'b0000, 1'b0);
        in_result    = 32'h99;
        in_tag       = 4'd8;
        in_nzcv      = 4'b0100;
        in_set_flags = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_set_flags = 1'b0;
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_apsr", apsr_nzcv, 4'b0010);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("flush_no_output", out_valid, 0);
        end

        // Reset mid-operation with a buffered beat and a pending input.
        out_ready = 1'b0;
        applyStimulus(32'h77, 4'd7, 4'b1000, 1'b1);
        in_valid = 1'b0;
        checkOutput("mid_apsr_before", apsr_nzcv, 4'b1000);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_nzcv  = 4'b0110;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_apsr", apsr_nzcv, 4'b0000);
        checkOutput("mid_rst_carry", carry_to_alu, 0);
        checkOutput("mid_rst_out_result", out_result, 0);
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        in_set_flags = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
